uart_stream_checker: RTL and testbench
======================================

Name: uart_stream_checker

Overview:
- Synthesizable, parametrised UART stream receiver and checker for on-chip and bench self-test.
- Deserialises a UART line, compares each received character against a programmable expected-message buffer, and latches a pass/fail verdict with error code and failing index.
- Sits on the SoC UART TX loopback or on a debug header; the verdict is readable through GPIO/LEDs.
- Generalises fixed 8N1 "Hello World!" checking to configurable frame format, message length and timeout.

Parameters:
- CLK_FREQ, 50_000_000: clock frequency in Hz.
- BAUD, 115200: line rate; DIVISOR = CLK_FREQ/BAUD, integer division, must be ≥4.
- DATA_BITS, 8: data bits per frame, 5..8, sent LSB first.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.
- MSG_DEPTH, 16: expected-buffer entries, power of 2; AW = log2(MSG_DEPTH).
- TO_W, 32: timeout counter width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- rx  in  1  asynchronous UART line, idle high.
- exp_we  in  1  write strobe for the expected buffer.
- exp_addr  in  AW  expected-buffer write address.
- exp_wdata  in  DATA_BITS  expected character.
- msg_len  in  AW+1  number of characters to check, 1..MSG_DEPTH; sampled on arm.
- timeout  in  TO_W  cycles allowed from arm to completion; 0 disables the timeout.
- arm  in  1  one-cycle pulse that starts a check.
- rx_valid  out  1  one-cycle pulse per accepted frame.
- rx_data  out  DATA_BITS  last received character.
- byte_idx  out  AW+1  characters checked so far.
- busy  out  1  high while armed and not done.
- done  out  1  verdict latched.
- pass  out  1  valid when done = 1.
- err_code  out  3  0 = none, 1 = framing, 2 = parity, 3 = mismatch, 4 = timeout.
- err_idx  out  AW+1  index of the first failing character.

Behaviour:
- Reset (rst_n = 0 at posedge clk): all outputs 0, FSM to IDLE, synchroniser flops to 1. Expected-buffer contents are not reset.
- rx passes through a 2-FF synchroniser. Edge detect is registered sync high → low. Total added latency is 3 cycles.
- exp_we writes in any state, including busy. A write to the index currently being compared is undefined.
- FSM states: IDLE, WAIT_START, START, DATA, PAR, STOP, DONE.
  - IDLE: arm → WAIT_START. Latch msg_len, clear byte_idx/err/done/pass, load timeout counter, busy = 1.
  - WAIT_START: falling edge → START, bit counter = DIVISOR/2 − 1.
  - START: at mid-bit, rx = 0 → DATA. rx = 1 is a glitch → WAIT_START, no error.
  - DATA: sample every DIVISOR cycles, DATA_BITS samples, shifted LSB first. Then → PAR if PARITY ≠ 0, else → STOP.
  - PAR: sample parity. Odd: XOR(data, p) = 1. Even: XOR(data, p) = 0. On failure, flag parity error.
  - STOP: sample STOP_BITS bits at DIVISOR spacing; any 0 flags framing error. After the last stop sample:
    - pulse rx_valid; rx_data updates the same cycle;
    - compare with exp[byte_idx] in this order: framing, then parity, then mismatch;
    - on any error: latch err_code and err_idx = byte_idx, → DONE, pass = 0;
    - otherwise byte_idx + 1; if the new value equals msg_len → DONE, pass = 1; else → WAIT_START.
  - DONE: done = 1, busy = 0. Outputs hold until the next arm or reset.
- Frame timing: next start-edge detection begins in the cycle after the final stop sample. A back-to-back frame whose start edge arrives half a stop bit later is accepted.
- Timeout:
  - when timeout ≠ 0, the counter decrements every cycle while busy;
  - reaching 0 in any non-DONE busy state → DONE with err_code = 4, err_idx = byte_idx;
  - if timeout expiry and a frame's final stop sample fall in the same cycle, the frame result wins.
- arm while busy restarts the check immediately and discards any partial frame. arm in DONE re-arms.
- rx activity in IDLE or DONE is ignored.
- rst_n low mid-frame aborts the check; no rx_valid is emitted.
- msg_len = 0 or msg_len > MSG_DEPTH: arm goes directly to DONE with pass = 0, err_code = 3, err_idx = 0.

Test Plan:
- Clean message: CLK_FREQ = 1_000_000, BAUD = 100_000 (DIVISOR = 10), 8N1. Load "Hello World!\n" (13 bytes), msg_len = 13, arm, drive the 13 frames. Required: 13 rx_valid pulses with data 0x48 … 0x0A, then done = 1, pass = 1, err_code = 0, byte_idx = 13.
- Mismatch: same setup, drive 0x58 at index 4. Required: done = 1, pass = 0, err_code = 3, err_idx = 4, rx_data = 0x58.
- Parity and framing: PARITY = 2, STOP_BITS = 2, expected 0x41. Send 0x41 with parity bit 1 → err_code = 2, err_idx = 0. Re-arm, send a good parity bit but second stop bit = 0 → err_code = 1.
- Glitch and back-to-back frames: a 3-cycle low pulse on idle rx → no rx_valid, still busy. Then two frames with only 1 stop bit and no idle gap (0x55, 0xAA) → both accepted, pass = 1.
- Timeout: timeout = 500, msg_len = 2, send one frame only. Required: done exactly 500 cycles after arm, err_code = 4, err_idx = 1.
- Reset and re-arm: rst_n low for 1 cycle during DATA of frame 0. Required: all outputs 0 and no rx_valid. Then arm plus a full message → pass = 1.

Source files
------------

// File: rtl/uart_stream_checker.sv
`timescale 1ns/1ps
// uart_stream_checker: UART receiver that checks each received character
// against a programmable expected-message buffer and latches a verdict.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   rx                    asynchronous UART line, idle high
//   exp_we/addr/wdata     expected-buffer write port (usable in any state)
//   msg_len, timeout      check length and cycle budget, sampled on arm
//   arm                   one-cycle pulse starting (or restarting) a check
//   rx_valid, rx_data     pulse per accepted frame, last received character
//   byte_idx              characters checked so far
//   busy, done, pass      check in progress / verdict latched / verdict
//   err_code, err_idx     0 none, 1 framing, 2 parity, 3 mismatch, 4 timeout;
//                         index of the first failing character
module uart_stream_checker #(
    parameter int unsigned CLK_FREQ  = 50_000_000,
    parameter int unsigned BAUD      = 115200,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1,
    parameter int unsigned MSG_DEPTH = 16,
    parameter int unsigned TO_W      = 32,
    localparam int unsigned AW       = $clog2(MSG_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    input  logic                 exp_we,
    input  logic [AW-1:0]        exp_addr,
    input  logic [DATA_BITS-1:0] exp_wdata,
    input  logic [AW:0]          msg_len,
    input  logic [TO_W-1:0]      timeout,
    input  logic                 arm,
    output logic                 rx_valid,
    output logic [DATA_BITS-1:0] rx_data,
    output logic [AW:0]          byte_idx,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2:0]           err_code,
    output logic [AW:0]          err_idx
);

    localparam int unsigned DIVISOR = CLK_FREQ / BAUD;
    localparam int unsigned CW      = $clog2(DIVISOR);
    localparam int unsigned BW      = $clog2(DATA_BITS + 1);
    localparam int unsigned IW      = AW + 1;

    localparam logic [CW-1:0] BIT_LAST  = CW'(DIVISOR - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(DIVISOR / 2 - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [1:0]    STOP_LAST = 2'(STOP_BITS - 1);
    localparam logic          ODD_PAR   = (PARITY == 1);

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_FRAME    = 3'd1;
    localparam logic [2:0] ERR_PARITY   = 3'd2;
    localparam logic [2:0] ERR_MISMATCH = 3'd3;
    localparam logic [2:0] ERR_TIMEOUT  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_START,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP,
        S_DONE
    } state_t;

    state_t               state;
    logic                 rx_meta, rx_sync, rx_sync_d, fall_r;
    logic [CW-1:0]        tick_cnt;
    logic [BW-1:0]        data_cnt;
    logic [1:0]           stop_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 frame_err, par_err;
    logic [AW:0]          len_q;
    logic [TO_W-1:0]      to_cnt;
    logic                 to_en;
    logic [DATA_BITS-1:0] exp_mem [MSG_DEPTH];

    logic                 tick_c, len_ok_c, to_hit_c, last_stop_c, frame_err_c;
    logic [AW:0]          idx_inc_c;
    logic [2:0]           frame_code_c;
    logic [DATA_BITS-1:0] exp_char_c;

    // Two-flop synchroniser plus registered falling-edge detect.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta   <= 1'b1;
            rx_sync   <= 1'b1;
            rx_sync_d <= 1'b1;
            fall_r    <= 1'b0;
        end else begin
            rx_meta   <= rx;
            rx_sync   <= rx_meta;
            rx_sync_d <= rx_sync;
            fall_r    <= rx_sync_d & ~rx_sync;
        end
    end

    // Expected-message buffer; contents survive reset.
    always_ff @(posedge clk) begin
        if (exp_we) begin
            exp_mem[exp_addr] <= exp_wdata;
        end
    end

    // Frame verdict in priority order framing > parity > mismatch.
    always_comb begin
        tick_c      = (tick_cnt == '0);
        len_ok_c    = (msg_len != '0) && (msg_len <= IW'(MSG_DEPTH));
        to_hit_c    = to_en && (to_cnt <= TO_W'(1));
        last_stop_c = (state == S_STOP) && tick_c && (stop_cnt == STOP_LAST);
        frame_err_c = frame_err | ~rx_sync;
        idx_inc_c   = byte_idx + IW'(1);
        exp_char_c  = exp_mem[byte_idx[AW-1:0]];
        if (frame_err_c) begin
            frame_code_c = ERR_FRAME;
        end else if (par_err) begin
            frame_code_c = ERR_PARITY;
        end else if (shreg != exp_char_c) begin
            frame_code_c = ERR_MISMATCH;
        end else begin
            frame_code_c = ERR_NONE;
        end
    end

    // Receive / check FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            tick_cnt  <= '0;
            data_cnt  <= '0;
            stop_cnt  <= '0;
            shreg     <= '0;
            frame_err <= 1'b0;
            par_err   <= 1'b0;
            len_q     <= '0;
            to_cnt    <= '0;
            to_en     <= 1'b0;
            rx_valid  <= 1'b0;
            rx_data   <= '0;
            byte_idx  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_code  <= ERR_NONE;
            err_idx   <= '0;
        end else begin
            rx_valid <= 1'b0;
            // Saturating countdown so a deadline that coincides with a
            // continuing frame still expires on the following cycle.
            if (busy && to_cnt != '0) begin
                to_cnt <= to_cnt - TO_W'(1);
            end

            if (arm) begin
                byte_idx <= '0;
                err_idx  <= '0;
                pass     <= 1'b0;
                len_q    <= msg_len;
                to_cnt   <= timeout;
                to_en    <= (timeout != '0);
                if (len_ok_c) begin
                    state    <= S_WAIT_START;
                    busy     <= 1'b1;
                    done     <= 1'b0;
                    err_code <= ERR_NONE;
                end else begin
                    state    <= S_DONE;
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    err_code <= ERR_MISMATCH;
                end
            end else if (busy && to_hit_c && !last_stop_c) begin
                state    <= S_DONE;
                busy     <= 1'b0;
                done     <= 1'b1;
                pass     <= 1'b0;
                err_code <= ERR_TIMEOUT;
                err_idx  <= byte_idx;
            end else begin
                case (state)
                    S_WAIT_START: begin
                        if (fall_r) begin
                            state    <= S_START;
                            tick_cnt <= HALF_LAST;
                        end
                    end
                    S_START: begin
                        if (tick_c) begin
                            if (!rx_sync) begin
                                state     <= S_DATA;
                                tick_cnt  <= BIT_LAST;
                                data_cnt  <= '0;
                                frame_err <= 1'b0;
                                par_err   <= 1'b0;
                            end else begin
                                state <= S_WAIT_START;
                            end
                        end else begin
                            tick_cnt <= tick_cnt - CW'(1);
                        end
                    end
                    S_DATA: begin
                        if (tick_c) begin
                            shreg    <= {rx_sync, shreg[DATA_BITS-1:1]};
                            tick_cnt <= BIT_LAST;
                            if (data_cnt == DATA_LAST) begin
                                stop_cnt <= '0;
                                state    <= (PARITY != 0) ? S_PAR : S_STOP;
                            end else begin
                                data_cnt <= data_cnt + BW'(1);
                            end
                        end else begin
                            tick_cnt <= tick_cnt - CW'(1);
                        end
                    end
                    S_PAR: begin
                        if (tick_c) begin
                            par_err  <= (^{shreg, rx_sync}) ^ ODD_PAR;
                            tick_cnt <= BIT_LAST;
                            state    <= S_STOP;
                        end else begin
                            tick_cnt <= tick_cnt - CW'(1);
                        end
                    end
                    S_STOP: begin
                        if (tick_c) begin
                            if (stop_cnt == STOP_LAST) begin
                                rx_valid <= 1'b1;
                                rx_data  <= shreg;
                                if (frame_code_c != ERR_NONE) begin
                                    state    <= S_DONE;
                                    busy     <= 1'b0;
                                    done     <= 1'b1;
                                    err_code <= frame_code_c;
                                    err_idx  <= byte_idx;
                                end else begin
                                    byte_idx <= idx_inc_c;
                                    if (idx_inc_c == len_q) begin
                                        state <= S_DONE;
                                        busy  <= 1'b0;
                                        done  <= 1'b1;
                                        pass  <= 1'b1;
                                    end else begin
                                        state <= S_WAIT_START;
                                    end
                                end
                            end else begin
                                frame_err <= frame_err_c;
                                stop_cnt  <= stop_cnt + 2'd1;
                                tick_cnt  <= BIT_LAST;
                            end
                        end else begin
                            tick_cnt <= tick_cnt - CW'(1);
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_stream_checker.sv
`timescale 1ns/1ps
// Bench for uart_stream_checker: an 8N1 instance and an 8E2 instance, driven
// with directed and randomised messages; verdicts come from a message-level
// reference model over the list of frames actually sent.
module tb_uart_stream_checker;

    localparam int DIV = 10;
    localparam int AW  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, rx_a, rx_b, arm_a, arm_b, exp_we;
    logic [AW-1:0] exp_addr;
    logic [7:0]    exp_wdata;
    logic [AW:0]   msg_len;
    logic [31:0]   timeout;

    logic          rx_valid_a, busy_a, done_a, pass_a;
    logic [7:0]    rx_data_a;
    logic [AW:0]   byte_idx_a, err_idx_a;
    logic [2:0]    err_code_a;
    logic          rx_valid_b, busy_b, done_b, pass_b;
    logic [7:0]    rx_data_b;
    logic [AW:0]   byte_idx_b, err_idx_b;
    logic [2:0]    err_code_b;

    uart_stream_checker #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8),
        .PARITY(0), .STOP_BITS(1), .MSG_DEPTH(16), .TO_W(32)) dut_a (
        .clk(clk), .rst_n(rst_n), .rx(rx_a), .exp_we(exp_we), .exp_addr(exp_addr),
        .exp_wdata(exp_wdata), .msg_len(msg_len), .timeout(timeout), .arm(arm_a),
        .rx_valid(rx_valid_a), .rx_data(rx_data_a), .byte_idx(byte_idx_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .err_code(err_code_a),
        .err_idx(err_idx_a));

    uart_stream_checker #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8),
        .PARITY(2), .STOP_BITS(2), .MSG_DEPTH(16), .TO_W(32)) dut_b (
        .clk(clk), .rst_n(rst_n), .rx(rx_b), .exp_we(exp_we), .exp_addr(exp_addr),
        .exp_wdata(exp_wdata), .msg_len(msg_len), .timeout(timeout), .arm(arm_b),
        .rx_valid(rx_valid_b), .rx_data(rx_data_b), .byte_idx(byte_idx_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .err_code(err_code_b),
        .err_idx(err_idx_b));

    int         n_checks = 0;
    int         n_err    = 0;
    logic [7:0] m_exp [16];
    logic [7:0] rxq_a[$];
    logic [7:0] rxq_b[$];
    logic [7:0] fq_d[$];
    bit         fq_p[$];
    bit         fq_s[$];

    // Capture every accepted character.
    always @(negedge clk) begin
        if (rx_valid_a) rxq_a.push_back(rx_data_a);
        if (rx_valid_b) rxq_b.push_back(rx_data_b);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic drive_bit(input bit sel, input logic v, input int cycles);
        if (sel) rx_b = v; else rx_a = v;
        repeat (cycles) @(negedge clk);
    endtask

    // sel 0: 8N1 line; sel 1: 8E2 line. stop_bad zeroes the final stop bit.
    task automatic frame(input bit sel, input logic [7:0] d, input bit par_bad,
                         input bit stop_bad, input int gap);
        logic p;
        int   nstop;
        fq_d.push_back(d);
        fq_p.push_back(par_bad);
        fq_s.push_back(stop_bad);
        nstop = sel ? 2 : 1;
        drive_bit(sel, 1'b0, DIV);
        for (int i = 0; i < 8; i++) drive_bit(sel, d[i], DIV);
        if (sel) begin
            p = (^d) ^ par_bad;
            drive_bit(sel, p, DIV);
        end
        for (int i = 0; i < nstop; i++)
            drive_bit(sel, (stop_bad && i == nstop - 1) ? 1'b0 : 1'b1, DIV);
        drive_bit(sel, 1'b1, gap);
    endtask

    task automatic write_exp(input int i, input logic [7:0] d);
        exp_we    = 1'b1;
        exp_addr  = AW'(i);
        exp_wdata = d;
        m_exp[i]  = d;
        @(negedge clk);
        exp_we = 1'b0;
    endtask

    task automatic do_arm(input bit sel, input int len, input int to);
        msg_len = 5'(len);
        timeout = 32'(to);
        if (sel) arm_b = 1'b1; else arm_a = 1'b1;
        @(negedge clk);
        arm_a = 1'b0;
        arm_b = 1'b0;
        rxq_a.delete(); rxq_b.delete();
        fq_d.delete(); fq_p.delete(); fq_s.delete();
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".a"}, 32'({rx_valid_a, rx_data_a, byte_idx_a, busy_a, done_a,
                              pass_a, err_code_a, err_idx_a}), 0);
        chk({tag, ".b"}, 32'({rx_valid_b, rx_data_b, byte_idx_b, busy_b, done_b,
                              pass_b, err_code_b, err_idx_b}), 0);
    endtask

    // Reference: walk the frames sent; the first bad one decides, otherwise
    // the message passes once len good characters have arrived.
    task automatic check_msg(input bit sel, input int len, input string tag);
        int         en = 0, ecode = 0, eidx = 0, epass = 0, ebidx = 0, code;
        bit         fin = 0;
        logic [7:0] q[$];
        for (int i = 0; i < fq_d.size() && !fin; i++) begin
            en++;
            if (fq_s[i]) code = 1;
            else if (fq_p[i]) code = 2;
            else if (fq_d[i] != m_exp[i]) code = 3;
            else code = 0;
            if (code != 0) begin
                ecode = code; eidx = i; fin = 1;
            end else begin
                ebidx = i + 1;
                if (ebidx == len) begin epass = 1; fin = 1; end
            end
        end
        repeat (4) @(negedge clk);
        if (sel) q = rxq_b; else q = rxq_a;
        chk({tag, ".done"},  32'(sel ? done_b : done_a), 32'(fin));
        chk({tag, ".busy"},  32'(sel ? busy_b : busy_a), 32'(!fin));
        chk({tag, ".pass"},  32'(sel ? pass_b : pass_a), epass);
        chk({tag, ".code"},  32'(sel ? err_code_b : err_code_a), ecode);
        chk({tag, ".eidx"},  32'(sel ? err_idx_b : err_idx_a), eidx);
        chk({tag, ".bidx"},  32'(sel ? byte_idx_b : byte_idx_a), ebidx);
        chk({tag, ".nvalid"}, q.size(), en);
        for (int k = 0; k < en && k < q.size(); k++)
            chk({tag, ".rxd"}, 32'(q[k]), 32'(fq_d[k]));
        if (en > 0)
            chk({tag, ".last"}, 32'(sel ? rx_data_b : rx_data_a), 32'(fq_d[en-1]));
    endtask

    task automatic load_hello();
        string s;
        s = "Hello World!\n";
        for (int i = 0; i < 13; i++) write_exp(i, s[i]);
    endtask

    task automatic send_hello();
        for (int i = 0; i < 13; i++) frame(0, m_exp[i], 0, 0, 2);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, len, bad, bad_i, kind, gap;
        logic [7:0] d;
        rst_n = 1'b0; rx_a = 1'b1; rx_b = 1'b1; arm_a = 1'b0; arm_b = 1'b0;
        exp_we = 1'b0; exp_addr = '0; exp_wdata = '0; msg_len = '0; timeout = '0;
        repeat (3) @(negedge clk);
        chk_reset("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Clean message and mismatch at index 4.
        load_hello();
        do_arm(0, 13, 0);
        send_hello();
        check_msg(0, 13, "hello");
        do_arm(0, 13, 0);
        for (int i = 0; i < 13; i++) frame(0, (i == 4) ? 8'h58 : m_exp[i], 0, 0, 2);
        check_msg(0, 13, "mismatch");

        // Parity, framing, then a good frame on the 8E2 line.
        write_exp(0, 8'h41);
        do_arm(1, 1, 0); frame(1, 8'h41, 1, 0, 4); check_msg(1, 1, "parity");
        do_arm(1, 1, 0); frame(1, 8'h41, 0, 1, 4); check_msg(1, 1, "framing");
        do_arm(1, 1, 0); frame(1, 8'h41, 0, 0, 4); check_msg(1, 1, "good_b");

        // Glitch is ignored; back-to-back frames are accepted.
        write_exp(0, 8'h55); write_exp(1, 8'hAA);
        do_arm(0, 2, 0);
        drive_bit(0, 1'b0, 3);
        drive_bit(0, 1'b1, 30);
        chk("glitch.nvalid", rxq_a.size(), 0);
        chk("glitch.busy", 32'(busy_a), 1);
        frame(0, 8'h55, 0, 0, 0);
        frame(0, 8'hAA, 0, 0, 0);
        check_msg(0, 2, "b2b");

        // Timeout after one of two frames.
        do_arm(0, 2, 500);
        n = 0;
        fork
            frame(0, 8'h55, 0, 0, 0);
            while (!done_a && n < 600) begin @(negedge clk); n++; end
        join
        chk("to.cycles", n, 500);
        chk("to.code", 32'(err_code_a), 4);
        chk("to.eidx", 32'(err_idx_a), 1);
        chk("to.pass", 32'(pass_a), 0);
        chk("to.nvalid", rxq_a.size(), 1);

        // Reset mid-frame, then a full message.
        load_hello();
        do_arm(0, 13, 0);
        fork
            frame(0, m_exp[0], 0, 0, 2);
            begin
                repeat (35) @(negedge clk);
                rst_n = 1'b0;
                @(negedge clk);
                chk_reset("midrst");
                rst_n = 1'b1;
            end
        join
        repeat (5) @(negedge clk);
        chk("midrst.nvalid", rxq_a.size(), 0);
        chk("midrst.idle", 32'({busy_a, done_a}), 0);
        do_arm(0, 13, 0);
        send_hello();
        check_msg(0, 13, "after_rst");

        // Illegal lengths finish immediately.
        do_arm(0, 0, 0);
        chk("len0", 32'({done_a, pass_a, err_code_a, err_idx_a, busy_a}), 32'({1'b1, 1'b0, 3'd3, 5'd0, 1'b0}));
        do_arm(0, 17, 0);
        chk("len17", 32'({done_a, pass_a, err_code_a, err_idx_a, busy_a}), 32'({1'b1, 1'b0, 3'd3, 5'd0, 1'b0}));

        // Re-arm mid-frame discards the partial character.
        do_arm(0, 13, 0);
        drive_bit(0, 1'b0, DIV);
        for (int i = 0; i < 3; i++) drive_bit(0, m_exp[0][i], DIV);
        drive_bit(0, 1'b1, 0);
        do_arm(0, 13, 0);
        drive_bit(0, 1'b1, 30);
        send_hello();
        check_msg(0, 13, "rearm");

        // Random messages on the 8N1 line with an optional mismatch.
        for (int it = 0; it < 5; it++) begin
            len = $urandom_range(1, 16);
            for (int i = 0; i < len; i++) write_exp(i, 8'($urandom_range(0, 255)));
            bad = $urandom_range(0, 1);
            bad_i = $urandom_range(0, len - 1);
            do_arm(0, len, 0);
            for (int i = 0; i < len; i++) begin
                d = m_exp[i];
                if (bad != 0 && i == bad_i) d = d ^ 8'($urandom_range(1, 255));
                frame(0, d, 0, 0, $urandom_range(0, 4));
            end
            check_msg(0, len, "rand_a");
        end

        // Random messages on the 8E2 line with parity/stop/data faults.
        for (int it = 0; it < 4; it++) begin
            len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++) write_exp(i, 8'($urandom_range(0, 255)));
            kind = $urandom_range(0, 3);
            bad_i = $urandom_range(0, len - 1);
            do_arm(1, len, 0);
            for (int i = 0; i < len; i++) begin
                d = m_exp[i];
                gap = $urandom_range(1, 4);
                if (i == bad_i && kind == 3) d = d ^ 8'($urandom_range(1, 255));
                frame(1, d, (i == bad_i && kind == 1), (i == bad_i && kind == 2), gap);
            end
            check_msg(1, len, "rand_b");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
